// File: rtl/user_io_bank.sv
// User IO bank: per-pin output mux (registered/combinational), input loopback,
// synchroniser and edge pulses. Define USER_IO_DEBOUNCE_EN to add per-pin debounce.

module user_io_lane #(
  parameter int SYNC_STAGES = 2
`ifdef USER_IO_DEBOUNCE_EN
  ,
  parameter int DB_CYCLES   = 16
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in_i,
  input  logic usr_out_i,
  input  logic usr_oeb_i,
  input  logic reg_en_i,
  input  logic lb_en_i,
  output logic pad_out_o,
  output logic pad_oeb_o,
  output logic usr_in_o,
  output logic rise_o,
  output logic fall_o
);

  logic                   out_q, oeb_q;
  logic                   src;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   in_q, in_d;
  logic                   rise_q, fall_q;

  // The registered copy samples every cycle so switching reg_en is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      oeb_q <= 1'b1;
    end else begin
      out_q <= usr_out_i;
      oeb_q <= usr_oeb_i;
    end
  end

  assign pad_out_o = reg_en_i ? out_q : usr_out_i;
  assign pad_oeb_o = ~rst_n | (reg_en_i ? oeb_q : usr_oeb_i);

  assign src      = lb_en_i ? pad_out_o : pad_in_i;
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], src};
  end

`ifdef USER_IO_DEBOUNCE_EN
  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with usr_in;
  // it clears on the update cycle, so it can never wrap.
  always_comb begin
    in_d  = in_q;
    cnt_d = '0;
    if (sync_out != in_q) begin
      if (cnt_q == CNT_MAX) in_d  = sync_out;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    in_d = sync_out;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      in_q   <= in_d;
      rise_q <= in_d & ~in_q;
      fall_q <= ~in_d & in_q;
    end
  end

  assign usr_in_o = in_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

module user_io_bank #(
  parameter int NUM_IO      = 48,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IO-1:0] pad_in,
  output logic [NUM_IO-1:0] pad_out,
  output logic [NUM_IO-1:0] pad_oeb,
  input  logic [NUM_IO-1:0] usr_out,
  input  logic [NUM_IO-1:0] usr_oeb,
  input  logic [NUM_IO-1:0] out_reg_en,
  input  logic              lb_en,
  output logic [NUM_IO-1:0] usr_in,
  output logic [NUM_IO-1:0] usr_rise,
  output logic [NUM_IO-1:0] usr_fall
);

  if (NUM_IO < 1 || NUM_IO > 128) begin : g_bad_num_io
    $error("user_io_bank: NUM_IO out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("user_io_bank: SYNC_STAGES out of range");
  end
  if (DB_CYCLES < 2 || DB_CYCLES > 256) begin : g_bad_db
    $error("user_io_bank: DB_CYCLES out of range");
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_lane
    user_io_lane #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef USER_IO_DEBOUNCE_EN
      ,
      .DB_CYCLES   (DB_CYCLES)
`endif
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .pad_in_i  (pad_in[i]),
      .usr_out_i (usr_out[i]),
      .usr_oeb_i (usr_oeb[i]),
      .reg_en_i  (out_reg_en[i]),
      .lb_en_i   (lb_en),
      .pad_out_o (pad_out[i]),
      .pad_oeb_o (pad_oeb[i]),
      .usr_in_o  (usr_in[i]),
      .rise_o    (usr_rise[i]),
      .fall_o    (usr_fall[i])
    );
  end

endmodule

// File: tb/tb_user_io_bank.sv
// Directed bench for user_io_bank; expected latency follows USER_IO_DEBOUNCE_EN.

module tb_user_io_bank;
  localparam int N  = 48;
  localparam int SS = 2;
  localparam int DB = 16;
`ifdef USER_IO_DEBOUNCE_EN
  localparam int LAT = SS + DB;
`else
  localparam int LAT = SS + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pad_in, pad_out, pad_oeb, usr_out, usr_oeb, out_reg_en;
  logic         lb_en;
  logic [N-1:0] usr_in, usr_rise, usr_fall;

  int vecs = 0;
  int errs = 0;

  user_io_bank #(.NUM_IO(N), .SYNC_STAGES(SS), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .pad_in(pad_in), .pad_out(pad_out), .pad_oeb(pad_oeb),
    .usr_out(usr_out), .usr_oeb(usr_oeb), .out_reg_en(out_reg_en), .lb_en(lb_en),
    .usr_in(usr_in), .usr_rise(usr_rise), .usr_fall(usr_fall)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pad_in = '0; usr_out = '0; usr_oeb = '0;
    out_reg_en = '0; lb_en = 1'b0;
    #1;
    chk("rst_oeb_comb", pad_oeb, {N{1'b1}});
    chk("rst_usr_in",   usr_in,  '0);
    chk("rst_rise",     usr_rise, '0);
    chk("rst_fall",     usr_fall, '0);
    out_reg_en = {N{1'b1}};
    #1;
    chk("rst_oeb_reg",  pad_oeb, {N{1'b1}});
    chk("rst_out_reg",  pad_out, '0);
    out_reg_en = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_oeb", pad_oeb, '0);

    // single-pin rise latency
    pad_in[5] = 1'b1;
    step(LAT - 1);
    chk("rise_early_in",   usr_in,   '0);
    chk("rise_early_rise", usr_rise, '0);
    step(1);
    chk("rise_in",   usr_in,   48'h20);
    chk("rise_rise", usr_rise, 48'h20);
    chk("rise_fall", usr_fall, '0);
    step(1);
    chk("rise_pulse_end", usr_rise, '0);

    // single-pin fall latency
    pad_in[5] = 1'b0;
    step(LAT - 1);
    chk("fall_early_in", usr_in, 48'h20);
    step(1);
    chk("fall_in",   usr_in,   '0);
    chk("fall_fall", usr_fall, 48'h20);
    chk("fall_rise", usr_rise, '0);
    step(1);
    chk("fall_pulse_end", usr_fall, '0);

    // many pins in parallel, including the top pin
    pad_in = 48'h8000_0F00_0003;
    step(LAT - 1);
    chk("par_early", usr_in, '0);
    step(1);
    chk("par_in",   usr_in,   48'h8000_0F00_0003);
    chk("par_rise", usr_rise, 48'h8000_0F00_0003);
    pad_in = '0;
    step(LAT);
    chk("par_back", usr_in, '0);
    chk("par_fall", usr_fall, 48'h8000_0F00_0003);
    step(2);

    // 10-cycle excursion on pin 0
    pad_in[0] = 1'b1;
    step(10);
    pad_in[0] = 1'b0;
`ifdef USER_IO_DEBOUNCE_EN
    step(LAT + 4);
    chk("glitch_reject", usr_in,   '0);
    chk("glitch_rise",   usr_rise, '0);
`else
    step(LAT - 10);
    chk("glitch_pass", usr_in, 48'h1);
    step(10);
    chk("glitch_end",  usr_in, '0);
    step(2);
`endif

    // reset pulse partway through an input transition
    pad_in[1] = 1'b1;
`ifdef USER_IO_DEBOUNCE_EN
    step(SS + 12);
`else
    step(1);
`endif
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrst_in", usr_in, '0);
    step(LAT - 1);
    chk("midrst_early", usr_in, '0);
    step(1);
    chk("midrst_in_full", usr_in, 48'h2);
    pad_in = '0;
    step(LAT + 2);
    chk("midrst_clear", usr_in, '0);

    // output mux, registered vs combinational
    out_reg_en[7] = 1'b1;
    step(2);
    usr_out[7] = 1'b1;
    #1;
    chk("omux_reg_hold", pad_out, '0);
    step(1);
    chk("omux_reg_next", pad_out, 48'h80);
    usr_out[7] = 1'b0;
    out_reg_en[7] = 1'b0;
    #1;
    chk("omux_comb_now", pad_out, '0);
    out_reg_en[7] = 1'b1;
    #1;
    chk("omux_switch_same_cycle", pad_out, 48'h80);
    usr_out[3] = 1'b1;
    #1;
    chk("omux_comb_pin3", pad_out, 48'h88);
    step(1);
    chk("omux_reg_updated", pad_out, 48'h08);
    out_reg_en = {N{1'b1}};
    usr_oeb = 48'hFFFF_0000_0000;
    #1;
    chk("oeb_reg_hold", pad_oeb, '0);
    step(1);
    chk("oeb_reg_next", pad_oeb, 48'hFFFF_0000_0000);
    usr_oeb = '0; out_reg_en = '0; usr_out = '0;
    step(2);

    // loopback ignores pad_in
    pad_in = {N{1'b1}};
    lb_en = 1'b1;
    usr_out = 48'hA5;
    #1;
    chk("lb_padout", pad_out, 48'hA5);
    step(LAT - 1);
    chk("lb_early", usr_in, '0);
    step(1);
    chk("lb_in",   usr_in,   48'hA5);
    chk("lb_rise", usr_rise, 48'hA5);
    step(1);
    chk("lb_rise_end", usr_rise, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
